// File: rtl/tdm_demux_rx.sv
// -----------------------------------------------------------------------------
// tdm_demux_rx
// Receive side of a serial time-division link. Each enabled sample carries one
// channel bit; a sync marker accompanies the slot-0 bit. The block hunts for
// sync, then tracks slot position and reassembles the N channel bits of each
// frame into a parallel word. Lock is held while sync keeps arriving on slot 0.
// Lock is dropped after MISS_MAX consecutive frames whose slot 0 has no sync.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high, highest priority
//   en         sample strobe; z and sync are only looked at when en=1
//   z          serial TDM bit
//   sync       frame marker, asserted together with the slot-0 bit
//   c          reassembled word, c[k] = bit received in slot k
//   valid      one-cycle pulse when c has been loaded with a complete frame
//   s          slot index of the next expected sample (0 while hunting)
//   locked     1 while frame alignment is held
//   frame_err  one-cycle pulse when sync arrives on a slot other than 0
// -----------------------------------------------------------------------------
module tdm_demux_rx #(
    parameter int N        = 4,
    parameter int SW       = $clog2(N),
    parameter int MISS_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          z,
    input  logic          sync,
    output logic [N-1:0]  c,
    output logic          valid,
    output logic [SW-1:0] s,
    output logic          locked,
    output logic          frame_err
);

    // The miss counter only ever holds 0..MISS_MAX-1.
    localparam int MW = (MISS_MAX > 1) ? $clog2(MISS_MAX) : 1;

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [SW-1:0] SLOT_ZERO = SW'(0);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);
    localparam logic [MW-1:0] MISS_ZERO = MW'(0);
    localparam logic [MW-1:0] MISS_ONE  = MW'(1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_MAX - 1);

    logic [0:0]    state_r;
    logic [SW-1:0] slot_r;
    logic [MW-1:0] miss_r;
    // Slots 0..N-2 are buffered; the slot N-1 bit goes straight into c.
    logic [N-2:0]  buf_r;

    // The slot register is only ever non-zero while locked, so it drives s directly.
    assign s      = slot_r;
    assign locked = (state_r == ST_LOCKED);

    // Frame alignment state machine, slot tracking and word assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_HUNT;
            slot_r    <= SLOT_ZERO;
            miss_r    <= MISS_ZERO;
            buf_r     <= '0;
            c         <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // Pulses last one cycle whether or not a sample arrives.
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (en) begin
                case (state_r)
                    ST_HUNT: begin
                        if (sync) begin
                            buf_r[0] <= z;
                            slot_r   <= SLOT_ONE;
                            state_r  <= ST_LOCKED;
                        end else begin
                            slot_r   <= SLOT_ZERO;
                        end
                    end
                    ST_LOCKED: begin
                        if (sync && (slot_r != SLOT_ZERO)) begin
                            // Misaligned sync: drop the partial frame and
                            // realign on this sample as slot 0.
                            frame_err <= 1'b1;
                            buf_r[0]  <= z;
                            slot_r    <= SLOT_ONE;
                            miss_r    <= MISS_ZERO;
                        end else if (slot_r == SLOT_ZERO) begin
                            if (sync) begin
                                miss_r   <= MISS_ZERO;
                                buf_r[0] <= z;
                                slot_r   <= SLOT_ONE;
                            end else if (miss_r == MISS_LAST) begin
                                // Too many frames without sync: give up lock.
                                state_r  <= ST_HUNT;
                                slot_r   <= SLOT_ZERO;
                                miss_r   <= MISS_ZERO;
                            end else begin
                                // Flywheel: keep decoding on the expected timing.
                                miss_r   <= miss_r + MISS_ONE;
                                buf_r[0] <= z;
                                slot_r   <= SLOT_ONE;
                            end
                        end else if (slot_r != SLOT_LAST) begin
                            buf_r[slot_r] <= z;
                            slot_r        <= slot_r + SLOT_ONE;
                        end else begin
                            c      <= {z, buf_r};
                            valid  <= 1'b1;
                            slot_r <= SLOT_ZERO;
                        end
                    end
                    default: begin
                        state_r <= ST_HUNT;
                        slot_r  <= SLOT_ZERO;
                        miss_r  <= MISS_ZERO;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_rx
// Self-checking bench for tdm_demux_rx (N=4, MISS_MAX=3). Directed scenarios
// check fixed expectations; a randomized run checks every output each cycle
// against an integer/array reference model kept in this file.
// -----------------------------------------------------------------------------
module tb_tdm_demux_rx;

    localparam int N        = 4;
    localparam int SW       = 2;
    localparam int MISS_MAX = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          z;
    logic          sync;
    logic [N-1:0]  c;
    logic          valid;
    logic [SW-1:0] s;
    logic          locked;
    logic          frame_err;

    int vectors;
    int miscompares;

    // Reference model state: plain integers and a bit array per slot.
    int m_locked;
    int m_slot;
    int m_miss;
    int m_buf [N];
    int m_c;
    int m_valid;
    int m_ferr;

    tdm_demux_rx #(.N(N), .SW(SW), .MISS_MAX(MISS_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .z         (z),
        .sync      (sync),
        .c         (c),
        .valid     (valid),
        .s         (s),
        .locked    (locked),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the reference model by one clock edge.
    task automatic model_edge(input int r, input int e, input int zz, input int ss);
        if (r != 0) begin
            m_locked = 0; m_slot = 0; m_miss = 0; m_c = 0; m_valid = 0; m_ferr = 0;
            for (int k = 0; k < N; k++) m_buf[k] = 0;
        end else begin
            m_valid = 0;
            m_ferr  = 0;
            if (e != 0) begin
                if (m_locked == 0) begin
                    if (ss != 0) begin
                        m_buf[0] = zz; m_slot = 1; m_locked = 1;
                    end
                end else if (ss != 0 && m_slot != 0) begin
                    m_ferr = 1; m_buf[0] = zz; m_slot = 1; m_miss = 0;
                end else if (m_slot == 0) begin
                    if (ss != 0) begin
                        m_miss = 0; m_buf[0] = zz; m_slot = 1;
                    end else if (m_miss + 1 == MISS_MAX) begin
                        m_locked = 0; m_slot = 0; m_miss = 0;
                    end else begin
                        m_miss = m_miss + 1; m_buf[0] = zz; m_slot = 1;
                    end
                end else if (m_slot < N - 1) begin
                    m_buf[m_slot] = zz; m_slot = m_slot + 1;
                end else begin
                    m_buf[N-1] = zz;
                    m_c = 0;
                    for (int k = 0; k < N; k++) m_c = m_c + (m_buf[k] << k);
                    m_valid = 1;
                    m_slot  = 0;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, and settle 1 time unit past the edge.
    task automatic step(input logic r, input logic e, input logic zz, input logic ss);
        rst = r; en = e; z = zz; sync = ss;
        @(posedge clk);
        model_edge(int'(r), int'(e), int'(zz), int'(ss));
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (c !== 4'b0000) begin miscompares++; $display("FAIL reset_c got=%b want=0000", c); end
        vectors++;
        if (valid !== 1'b0 || frame_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_pulses got valid=%b ferr=%b want 0 0", valid, frame_err);
        end
        vectors++;
        if (s !== 2'd0 || locked !== 1'b0) begin
            miscompares++; $display("FAIL reset_state got s=%0d locked=%b want 0 0", s, locked);
        end
    endtask

    task automatic test_basic_frame();
        logic       zb [4];
        logic [1:0] s_exp [4];
        zb = '{1'b1, 1'b0, 1'b1, 1'b1};
        s_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, zb[k], (k == 0) ? 1'b1 : 1'b0);
            vectors++;
            if (s !== s_exp[k]) begin miscompares++; $display("FAIL basic_s slot=%0d got=%0d want=%0d", k, s, s_exp[k]); end
            vectors++;
            if (locked !== 1'b1) begin miscompares++; $display("FAIL basic_locked slot=%0d got=%b want=1", k, locked); end
            vectors++;
            if (valid !== ((k == 3) ? 1'b1 : 1'b0)) begin
                miscompares++; $display("FAIL basic_valid slot=%0d got=%b", k, valid);
            end
        end
        vectors++;
        if (c !== 4'b1101) begin miscompares++; $display("FAIL basic_c got=%b want=1101", c); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_pulse got=%b want=0", valid); end
    endtask

    task automatic test_en_gaps();
        logic       zb [4];
        logic [1:0] s_exp [4];
        zb = '{1'b1, 1'b0, 1'b1, 1'b1};
        s_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, zb[k], (k == 0) ? 1'b1 : 1'b0);
            vectors++;
            if (valid !== ((k == 3) ? 1'b1 : 1'b0)) begin
                miscompares++; $display("FAIL gaps_valid slot=%0d got=%b", k, valid);
            end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                vectors++;
                if (s !== s_exp[k] || valid !== 1'b0 || frame_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL gaps_hold slot=%0d got s=%0d valid=%b ferr=%b want s=%0d 0 0",
                             k, s, valid, frame_err, s_exp[k]);
                end
            end
        end
        vectors++;
        if (c !== 4'b1101) begin miscompares++; $display("FAIL gaps_c got=%b want=1101", c); end
    endtask

    task automatic test_misaligned_sync();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1);   // sync on slot 2, z=0 becomes new slot 0
        vectors++;
        if (frame_err !== 1'b1 || valid !== 1'b0 || s !== 2'd1) begin
            miscompares++; $display("FAIL misalign_err got ferr=%b valid=%b s=%0d want 1 0 1", frame_err, valid, s);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (frame_err !== 1'b0 || s !== 2'd2) begin
            miscompares++; $display("FAIL misalign_pulse got ferr=%b s=%0d want 0 2", frame_err, s);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (valid !== 1'b1 || c !== 4'b1100) begin
            miscompares++; $display("FAIL misalign_c got valid=%b c=%b want 1 1100", valid, c);
        end
    endtask

    task automatic test_loss_of_lock();
        logic [3:0] w;
        logic [3:0] last_c;
        last_c = c;
        // One synced frame, then two frames that survive without sync.
        for (int f = 0; f < 3; f++) begin
            w = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) step(1'b0, 1'b1, w[k], (f == 0 && k == 0) ? 1'b1 : 1'b0);
            vectors++;
            if (valid !== 1'b1 || c !== w || locked !== 1'b1) begin
                miscompares++; $display("FAIL lol_frame f=%0d got valid=%b c=%b locked=%b want 1 %b 1", f, valid, c, locked, w);
            end
            last_c = w;
        end
        // Third missing sync: lock drops at slot 0.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (locked !== 1'b0 || s !== 2'd0 || valid !== 1'b0) begin
            miscompares++; $display("FAIL lol_drop got locked=%b s=%0d valid=%b want 0 0 0", locked, s, valid);
        end
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            vectors++;
            if (locked !== 1'b0 || s !== 2'd0 || valid !== 1'b0 || c !== last_c) begin
                miscompares++; $display("FAIL lol_ignore k=%0d got locked=%b s=%0d valid=%b c=%b", k, locked, s, valid, c);
            end
        end
        step(1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (locked !== 1'b1 || s !== 2'd1) begin
            miscompares++; $display("FAIL lol_relock got locked=%b s=%0d want 1 1", locked, s);
        end
        for (int k = 1; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (valid !== 1'b1 || c !== 4'b0001) begin
            miscompares++; $display("FAIL lol_relock_c got valid=%b c=%b want 1 0001", valid, c);
        end
    endtask

    task automatic test_reset_midframe();
        logic zb [4];
        zb = '{1'b0, 1'b1, 1'b1, 1'b0};
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (c !== 4'b0000 || valid !== 1'b0 || locked !== 1'b0 || s !== 2'd0 || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst got c=%b valid=%b locked=%b s=%0d ferr=%b want all 0", c, valid, locked, s, frame_err);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, zb[k], (k == 0) ? 1'b1 : 1'b0);
        vectors++;
        if (valid !== 1'b1 || c !== 4'b0110) begin
            miscompares++; $display("FAIL midrst_frame got valid=%b c=%b want 1 0110", valid, c);
        end
    endtask

    task automatic test_hunt_en0();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            vectors++;
            if (locked !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0) begin
                miscompares++; $display("FAIL hunt_en0 k=%0d got locked=%b valid=%b ferr=%b", k, locked, valid, frame_err);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (locked !== 1'b1 || s !== 2'd1) begin
            miscompares++; $display("FAIL hunt_lock got locked=%b s=%0d want 1 1", locked, s);
        end
    endtask

    task automatic test_random();
        logic e, zz, ss;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            e  = ($urandom_range(0, 9) < 7);
            zz = 1'($urandom_range(0, 1));
            if (m_slot == 0) ss = ($urandom_range(0, 9) < 7);
            else             ss = ($urandom_range(0, 29) == 0);
            step(($urandom_range(0, 499) == 0), e, zz, ss);
            vectors++;
            if (c !== 4'(m_c) || valid !== 1'(m_valid) || frame_err !== 1'(m_ferr) ||
                locked !== 1'(m_locked) || s !== 2'(m_slot)) begin
                miscompares++;
                $display("FAIL random i=%0d got c=%b v=%b fe=%b lk=%b s=%0d want c=%b v=%0d fe=%0d lk=%0d s=%0d",
                         i, c, valid, frame_err, locked, s, 4'(m_c), m_valid, m_ferr, m_locked, m_slot);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; en = 1'b0; z = 1'b0; sync = 1'b0;
        model_edge(1, 0, 0, 0);
        test_reset();
        test_basic_frame();
        test_en_gaps();
        test_misaligned_sync();
        test_loss_of_lock();
        test_reset_midframe();
        test_hunt_en0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
